// File: rtl/sync_buck_pwm_ctrl_pkg.sv
// Shared state encodings and elaboration helpers for the synchronous buck PWM controller.
package sync_buck_pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    ADC_IDLE,
    ADC_CONV,
    ADC_WAIT_HI,
    ADC_WAIT_LO,
    ADC_READ
  } adcState_t;

  typedef enum logic [2:0] {
    PWM_OFF,
    PWM_HS,
    PWM_DT1,
    PWM_LS,
    PWM_DT2
  } pwmState_t;

  function automatic int clampDuty(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  // LS must keep at least one clock after both deadtimes at maximum duty.
  function automatic bit dutyMaxOk(input int cntW, input int deadtime, input int dutyMax);
    return dutyMax <= (2 ** cntW) - 2 * deadtime - 1;
  endfunction

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_buck_pwm_ctrl_if.sv
// Parallel ADC pin bundle: conversion start, busy, active-low read strobe and data.
interface sync_buck_pwm_ctrl_if #(
  parameter int ADC_W = 8
);
  logic             conv_start;
  logic             rd_cs;
  logic             busy;
  logic [ADC_W-1:0] adc_data;

  modport master (output conv_start, output rd_cs, input busy, input adc_data);
  modport slave  (input conv_start, input rd_cs, output busy, output adc_data);
endinterface

// File: rtl/sync_buck_pwm_ctrl_adc_conv_seq.sv
// Heartbeat-driven ADC conversion sequencer with busy timeout; latches the sample on the last read cycle.
//  state       | meaning
//  ADC_IDLE    | waiting for heartbeat request
//  ADC_CONV    | conv_start high for CONV_PW clocks
//  ADC_WAIT_HI | waiting for busy to rise
//  ADC_WAIT_LO | waiting for busy to fall
//  ADC_READ    | rd_cs low for RD_PW clocks
module sync_buck_pwm_ctrl_adc_conv_seq
  import sync_buck_pwm_ctrl_pkg::*;
#(
  parameter int ADC_W   = 8,
  parameter int HB_TIME = 1024,
  parameter int CONV_PW = 10,
  parameter int RD_PW   = 10,
  parameter int BUSY_TO = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  sync_buck_pwm_ctrl_if.master adc,
  output logic [ADC_W-1:0]     sample,
  output logic                 sampleValid,
  output logic                 adcTimeout
);
  localparam int TMR_W = $clog2(maxOf3(CONV_PW, RD_PW, BUSY_TO) + 1);
  localparam int HB_W  = $clog2(HB_TIME + 1);

  adcState_t        state, stateNext;
  logic [TMR_W-1:0] tmr, tmrNext;
  logic [HB_W-1:0]  hbCnt;
  logic             hbReq, tc, latchNow, timeoutNow;
  logic             convStartC, rdCsC;

  assign hbReq = enable && (hbCnt == '0) && (state == ADC_IDLE);
  assign tc    = (tmr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ADC_IDLE;
      tmr   <= '0;
    end else begin
      state <= stateNext;
      tmr   <= tmrNext;
    end
  end

  always_comb begin
    stateNext  = state;
    tmrNext    = tmr;
    latchNow   = 1'b0;
    timeoutNow = 1'b0;
    case (state)
      ADC_IDLE: begin
        if (hbReq) begin
          stateNext = ADC_CONV;
          tmrNext   = TMR_W'(CONV_PW - 1);
        end
      end
      ADC_CONV: begin
        if (tc) begin
          stateNext = ADC_WAIT_HI;
          tmrNext   = TMR_W'(BUSY_TO - 1);
        end else tmrNext = tmr - TMR_W'(1);
      end
      ADC_WAIT_HI: begin
        if (adc.busy) begin
          stateNext = ADC_WAIT_LO;
          tmrNext   = TMR_W'(BUSY_TO - 1);
        end else if (tc) begin
          stateNext  = ADC_IDLE;
          timeoutNow = 1'b1;
        end else tmrNext = tmr - TMR_W'(1);
      end
      ADC_WAIT_LO: begin
        if (!adc.busy) begin
          stateNext = ADC_READ;
          tmrNext   = TMR_W'(RD_PW - 1);
        end else if (tc) begin
          stateNext  = ADC_IDLE;
          timeoutNow = 1'b1;
        end else tmrNext = tmr - TMR_W'(1);
      end
      ADC_READ: begin
        if (tc) begin
          stateNext = ADC_IDLE;
          latchNow  = 1'b1;
        end else tmrNext = tmr - TMR_W'(1);
      end
      default: stateNext = ADC_IDLE;
    endcase
    // Disable aborts any conversion or read in flight.
    if (!enable) begin
      stateNext  = ADC_IDLE;
      tmrNext    = '0;
      latchNow   = 1'b0;
      timeoutNow = 1'b0;
    end
  end

  always_comb begin
    convStartC = (state == ADC_CONV);
    rdCsC      = (state != ADC_READ);
  end

  assign adc.conv_start = convStartC;
  assign adc.rd_cs      = rdCsC;

  always_ff @(posedge clk) begin
    if (reset) begin
      hbCnt       <= '0;
      sample      <= '0;
      sampleValid <= 1'b0;
      adcTimeout  <= 1'b0;
    end else begin
      sampleValid <= latchNow;
      adcTimeout  <= timeoutNow;
      if (latchNow) sample <= adc.adc_data;
      if (!enable) hbCnt <= '0;
      else if (hbCnt == HB_W'(HB_TIME - 1)) hbCnt <= '0;
      else hbCnt <= hbCnt + HB_W'(1);
    end
  end

endmodule

// File: rtl/sync_buck_pwm_ctrl.sv
// Synchronous buck controller: ADC-derived duty target, deadtime-protected PWM and fault latch.
// Build macro PWM_SOFTSTART_EN slews duty one count per period toward the target.
//  state   | meaning
//  PWM_OFF | gates off (disabled, fault or reset)
//  PWM_HS  | high-side on for duty clocks
//  PWM_DT1 | deadtime after high-side
//  PWM_LS  | low-side on for the rest of the period
//  PWM_DT2 | deadtime before the next high-side
module sync_buck_pwm_ctrl
  import sync_buck_pwm_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int ADC_W    = 8,
  parameter int DEADTIME = 5,
  parameter int DUTY_MIN = 3,
  parameter int DUTY_MAX = 240,
  parameter int HB_TIME  = 1024,
  parameter int CONV_PW  = 10,
  parameter int RD_PW    = 10,
  parameter int BUSY_TO  = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fault_in,
  sync_buck_pwm_ctrl_if.master adc,
  output logic                 gate_hs,
  output logic                 gate_ls,
  output logic [CNT_W-1:0]     duty,
  output logic                 sample_valid,
  output logic                 adc_timeout,
  output logic                 fault_latched
);
  localparam int PER     = 2 ** CNT_W;
  localparam int LS_BASE = PER - 2 * DEADTIME - 1;

  if (!dutyMaxOk(CNT_W, DEADTIME, DUTY_MAX)) begin : g_dutyMaxCheck
    $error("DUTY_MAX exceeds PER-2*DEADTIME-1");
  end

  logic [ADC_W-1:0] sample;
  logic [CNT_W-1:0] scaled, target, dutyNew;
  pwmState_t        pwmState, pwmStateNext;
  logic [CNT_W-1:0] pwmTmr, pwmTmrNext;
  logic             tc, loadDuty, gateHsNext, gateLsNext;

  sync_buck_pwm_ctrl_adc_conv_seq #(
    .ADC_W  (ADC_W),
    .HB_TIME(HB_TIME),
    .CONV_PW(CONV_PW),
    .RD_PW  (RD_PW),
    .BUSY_TO(BUSY_TO)
  ) u_adcConvSeq (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .adc        (adc),
    .sample     (sample),
    .sampleValid(sample_valid),
    .adcTimeout (adc_timeout)
  );

  if (ADC_W > CNT_W) begin : g_scaleDown
    assign scaled = sample[ADC_W-1 -: CNT_W];
  end else begin : g_scaleExt
    assign scaled = CNT_W'(sample);
  end

  assign target = CNT_W'(clampDuty(int'(scaled), DUTY_MIN, DUTY_MAX));

  always_comb begin
`ifdef PWM_SOFTSTART_EN
    if (pwmState == PWM_OFF) dutyNew = CNT_W'(DUTY_MIN);
    else if (duty < target)  dutyNew = duty + CNT_W'(1);
    else if (duty > target)  dutyNew = duty - CNT_W'(1);
    else                     dutyNew = duty;
`else
    dutyNew = target;
`endif
  end

  assign tc = (pwmTmr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwmState <= PWM_OFF;
      pwmTmr   <= '0;
      gate_hs  <= 1'b0;
      gate_ls  <= 1'b0;
    end else begin
      pwmState <= pwmStateNext;
      pwmTmr   <= pwmTmrNext;
      gate_hs  <= gateHsNext;
      gate_ls  <= gateLsNext;
    end
  end

  // Phase lengths sum to PER: duty + DEADTIME + (PER-duty-2*DEADTIME) + DEADTIME.
  always_comb begin
    pwmStateNext = pwmState;
    pwmTmrNext   = pwmTmr;
    loadDuty     = 1'b0;
    case (pwmState)
      PWM_OFF: begin
        pwmStateNext = PWM_HS;
        pwmTmrNext   = dutyNew - CNT_W'(1);
        loadDuty     = 1'b1;
      end
      PWM_HS: begin
        if (tc) begin
          pwmStateNext = PWM_DT1;
          pwmTmrNext   = CNT_W'(DEADTIME - 1);
        end else pwmTmrNext = pwmTmr - CNT_W'(1);
      end
      PWM_DT1: begin
        if (tc) begin
          pwmStateNext = PWM_LS;
          pwmTmrNext   = CNT_W'(LS_BASE) - duty;
        end else pwmTmrNext = pwmTmr - CNT_W'(1);
      end
      PWM_LS: begin
        if (tc) begin
          pwmStateNext = PWM_DT2;
          pwmTmrNext   = CNT_W'(DEADTIME - 1);
        end else pwmTmrNext = pwmTmr - CNT_W'(1);
      end
      PWM_DT2: begin
        if (tc) begin
          pwmStateNext = PWM_HS;
          pwmTmrNext   = dutyNew - CNT_W'(1);
          loadDuty     = 1'b1;
        end else pwmTmrNext = pwmTmr - CNT_W'(1);
      end
      default: pwmStateNext = PWM_OFF;
    endcase
    if (!enable || fault_in || fault_latched) begin
      pwmStateNext = PWM_OFF;
      pwmTmrNext   = '0;
      loadDuty     = 1'b0;
    end
  end

  always_comb begin
    gateHsNext = (pwmStateNext == PWM_HS);
    gateLsNext = (pwmStateNext == PWM_LS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty          <= CNT_W'(DUTY_MIN);
      fault_latched <= 1'b0;
    end else begin
      if (loadDuty) duty <= dutyNew;
      if (!enable) fault_latched <= 1'b0;
      else if (fault_in) fault_latched <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_buck_pwm_ctrl.sv
// Directed bench for sync_buck_pwm_ctrl: PWM phase lengths, duty limits, fault, timeout, abort, reset.
module tb_sync_buck_pwm_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, faultIn;
  logic       gateHs, gateLs, sampleValid, adcTimeout, faultLatched;
  logic [7:0] duty;
  bit         busyMode;
  int         nChecks = 0;
  int         nFails = 0;
  int         cycle = 0;
  int         overlapCnt = 0;
  int         minGap = 1 << 30;

  sync_buck_pwm_ctrl_if #(.ADC_W(8)) adcBus ();

  sync_buck_pwm_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fault_in     (faultIn),
    .adc          (adcBus),
    .gate_hs      (gateHs),
    .gate_ls      (gateLs),
    .duty         (duty),
    .sample_valid (sampleValid),
    .adc_timeout  (adcTimeout),
    .fault_latched(faultLatched)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkEq(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs != exp) begin
      nFails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ADC model: busy rises once conv_start drops and stays high 20 clocks.
  initial begin
    adcBus.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busyMode && adcBus.conv_start) begin
        while (adcBus.conv_start) @(negedge clk);
        adcBus.busy = 1'b1;
        repeat (20) @(negedge clk);
        adcBus.busy = 1'b0;
      end
    end
  end

  // Gate monitor: overlap count and shortest both-low gap before any gate rises.
  initial begin
    int  lowRun;
    bit  seenGate, prevHs, prevLs;
    lowRun = 0; seenGate = 0; prevHs = 0; prevLs = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (gateHs && gateLs) overlapCnt++;
        if (!gateHs && !gateLs) lowRun++;
        else begin
          if (((gateHs && !prevHs) || (gateLs && !prevLs)) && seenGate && lowRun < minGap)
            minGap = lowRun;
          lowRun   = 0;
          seenGate = 1;
        end
        prevHs = gateHs;
        prevLs = gateLs;
      end
    end
  end

  task automatic waitSample(input int budget, output bit got);
    int g;
    g = 0;
    @(negedge clk);
    while (!sampleValid && g < budget) begin @(negedge clk); g++; end
    got = sampleValid;
  endtask

  task automatic waitHsRise(output bit ok);
    int g;
    g = 0;
    @(negedge clk);
    while (gateHs && g < 600) begin @(negedge clk); g++; end
    while (!gateHs && g < 600) begin @(negedge clk); g++; end
    ok = (g < 600);
  endtask

  task automatic measurePeriod(output int hsLen, output int dt1, output int lsLen,
                               output int dt2, output int dutySeen);
    int g;
    g = 0; hsLen = 0; dt1 = 0; lsLen = 0; dt2 = 0; dutySeen = -1;
    @(negedge clk);
    while (gateHs && g < 600) begin @(negedge clk); g++; end
    while (!gateHs && g < 600) begin @(negedge clk); g++; end
    if (gateHs) dutySeen = int'(duty);
    while (gateHs && g < 1200) begin hsLen++; @(negedge clk); g++; end
    while (!gateHs && !gateLs && g < 1200) begin dt1++; @(negedge clk); g++; end
    while (gateLs && g < 1200) begin lsLen++; @(negedge clk); g++; end
    while (!gateHs && !gateLs && g < 1200) begin dt2++; @(negedge clk); g++; end
  endtask

  initial begin
    bit got, ok, okAll;
    int hsLen, dt1, lsLen, dt2, dutySeen, n, g, tConv0, tConv1, svCnt;

    reset = 1'b1; enable = 1'b0; faultIn = 1'b0; busyMode = 1'b1;
    adcBus.adc_data = 8'd128;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checkEq("rst_conv_start", adcBus.conv_start, 0);
    checkEq("rst_rd_cs", adcBus.rd_cs, 1);
    checkEq("rst_gate_hs", gateHs, 0);
    checkEq("rst_gate_ls", gateLs, 0);
    checkEq("rst_duty", duty, 3);
    checkEq("rst_sample_valid", sampleValid, 0);
    checkEq("rst_adc_timeout", adcTimeout, 0);
    checkEq("rst_fault_latched", faultLatched, 0);

`ifdef PWM_SOFTSTART_EN
    adcBus.adc_data = 8'd50;
    enable = 1'b1;
    @(posedge clk); #1;
    checkEq("ss_p0_duty", duty, 3);
    okAll = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      waitHsRise(ok);
      okAll &= ok;
      if (k == 1)  checkEq("ss_p1_duty", duty, 4);
      if (k == 46) checkEq("ss_p46_duty", duty, 49);
      if (k == 47) checkEq("ss_p47_duty", duty, 50);
      if (k == 48) checkEq("ss_p48_duty", duty, 50);
    end
    checkEq("ss_hs_rise_seen", okAll, 1);
`else
    // Duty 128 with 20-clock busy
    enable = 1'b1;
    waitSample(2000, got);
    checkEq("t1_sample_seen", got, 1);
    measurePeriod(hsLen, dt1, lsLen, dt2, dutySeen);
    checkEq("t1_hs_len", hsLen, 128);
    checkEq("t1_dt1_len", dt1, 5);
    checkEq("t1_ls_len", lsLen, 118);
    checkEq("t1_dt2_len", dt2, 5);
    checkEq("t1_period", hsLen + dt1 + lsLen + dt2, 256);
    checkEq("t1_duty", dutySeen, 128);

    // Clamp at both ends
    adcBus.adc_data = 8'd0;
    waitSample(1500, got);
    checkEq("t2_lo_sample_seen", got, 1);
    measurePeriod(hsLen, dt1, lsLen, dt2, dutySeen);
    checkEq("t2_lo_hs_len", hsLen, 3);
    checkEq("t2_lo_duty", dutySeen, 3);
    adcBus.adc_data = 8'd255;
    waitSample(1500, got);
    checkEq("t2_hi_sample_seen", got, 1);
    measurePeriod(hsLen, dt1, lsLen, dt2, dutySeen);
    checkEq("t2_hi_hs_len", hsLen, 240);
    checkEq("t2_hi_duty", dutySeen, 240);
    checkEq("t2_hi_ls_len", lsLen, 6);

    // Fault mid-HS, sticky until enable drop
    repeat (50) @(negedge clk);
    checkEq("t3_pre_fault_hs", gateHs, 1);
    faultIn = 1'b1;
    @(posedge clk); #1;
    checkEq("t3_fault_gate_hs", gateHs, 0);
    checkEq("t3_fault_gate_ls", gateLs, 0);
    checkEq("t3_fault_latched", faultLatched, 1);
    @(negedge clk); faultIn = 1'b0;
    repeat (10) @(negedge clk);
    checkEq("t3_sticky_gates", gateHs | gateLs, 0);
    checkEq("t3_sticky_latch", faultLatched, 1);
    busyMode = 1'b0;
    enable = 1'b0;
    g = 0;
    repeat (3) @(negedge clk);
    while (adcBus.busy && g < 40) begin @(negedge clk); g++; end
    checkEq("t3_cleared_latch", faultLatched, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    checkEq("t3_resume_hs", gateHs, 1);
    tConv0 = cycle;

    // Busy stuck low: timeout, duty retained, heartbeat retry
    g = 0;
    while (adcBus.conv_start && g < 40) begin @(negedge clk); g++; end
    n = 0;
    while (!adcTimeout && n < 400) begin n++; @(negedge clk); end
    checkEq("t4_timeout_clks", n, 255);
    @(negedge clk);
    checkEq("t4_timeout_pulse_width", adcTimeout, 0);
    checkEq("t4_duty_retained", duty, 240);
    g = 0;
    while (!adcBus.conv_start && g < 1100) begin @(negedge clk); g++; end
    tConv1 = cycle;
    checkEq("t4_retry_interval", tConv1 - tConv0, 1024);
    g = 0;
    while (adcBus.conv_start && g < 40) begin @(negedge clk); g++; end
    n = 0;
    while (!adcTimeout && n < 400) begin n++; @(negedge clk); end
    checkEq("t4_retry_timeout_clks", n, 255);
    busyMode = 1'b1;

    // Enable drop during READ aborts the read
    g = 0;
    while (adcBus.rd_cs && g < 1200) begin @(negedge clk); g++; end
    checkEq("t5_read_started", adcBus.rd_cs, 0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    checkEq("t5_abort_rd_cs", adcBus.rd_cs, 1);
    checkEq("t5_abort_gates", gateHs | gateLs, 0);
    svCnt = 0;
    repeat (15) begin @(negedge clk); if (sampleValid) svCnt++; end
    checkEq("t5_no_sample_after_abort", svCnt, 0);

    // Reset in the middle of HS
    adcBus.adc_data = 8'd128;
    enable = 1'b1;
    waitSample(200, got);
    checkEq("t6_sample_seen", got, 1);
    waitHsRise(ok);
    repeat (20) @(negedge clk);
    checkEq("t6_pre_reset_hs", gateHs, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkEq("t6_reset_gate_hs", gateHs, 0);
    checkEq("t6_reset_gate_ls", gateLs, 0);
    checkEq("t6_reset_duty", duty, 3);
    checkEq("t6_reset_rd_cs", adcBus.rd_cs, 1);
    checkEq("t6_reset_conv_start", adcBus.conv_start, 0);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
`endif

    checkEq("gate_overlap_cycles", overlapCnt, 0);
    checkEq("min_dead_gap_ge_5", int'(minGap >= 5), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
